// File: rtl/ram_pkg.sv
// Shared definitions for the RAM port arbiter and the MMIO decoder in front of it:
// default bus widths, arbiter state encoding and RAM operation codes.
package ram_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int BURST_CNT_W = 8;

    localparam logic RAM_OP_READ  = 1'b0;
    localparam logic RAM_OP_WRITE = 1'b1;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Saturating increment so a long uncontended burst never wraps back to a small count.
    function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] v);
        logic [BURST_CNT_W-1:0] r;
        if (v == {BURST_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + BURST_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first set request found
// when scanning upward from the slot after `last`, wrapping around.
module rr_pick #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         grant
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Scan N_REQ slots starting at last+1; only the first hit sets its grant bit.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_s        = IDX_W'((int'(last) + k) % N_REQ);
            grant[idx_s] = grant[idx_s] | (~found_s & req[idx_s]);
            found_s      = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among N_REQ requesters, with bounded
// burst locking and a registered one-cycle-later response.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [N_REQ-1:0]         req_op,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_write,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [ADDR_W-1:0]        phy_ram_addr,
    output logic [DATA_W-1:0]        phy_ram_write,
    output logic                     phy_ram_op,
    input  logic [DATA_W-1:0]        phy_ram_read
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);

    arb_state_t             state_r;
    arb_state_t             state_next_s;
    logic [IDX_W-1:0]       last_r;
    logic [IDX_W-1:0]       owner_r;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [BURST_CNT_W-1:0] burst_cnt_r;
    logic [N_REQ-1:0]       rr_grant_s;
    logic [N_REQ-1:0]       owner_mask_s;
    logic [N_REQ-1:0]       grant_s;
    logic                   others_valid_s;
    logic                   hold_active_s;
    logic                   accept_s;
    logic                   grant_lock_s;
    logic                   grant_op_s;
    logic [N_REQ-1:0]       rsp_valid_r;
    logic [DATA_W-1:0]      rsp_data_r;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req   (req_valid),
        .last  (last_r),
        .grant (rr_grant_s)
    );

    // The owner keeps the port unless it has used its burst budget while someone else waits.
    always_comb begin
        owner_mask_s   = N_REQ'(1) << owner_r;
        others_valid_s = |(req_valid & ~owner_mask_s);
        if (state_r == HOLD) begin
            hold_active_s = req_valid[owner_r] &&
                            !((burst_cnt_r >= BURST_LIMIT) && others_valid_s);
        end else begin
            hold_active_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: any accepted locked transfer lands in HOLD, including a re-arbitrated one out of HOLD.
    always_comb begin
        state_next_s = ARB;
        case (state_r)
            ARB:     state_next_s = (accept_s && grant_lock_s) ? HOLD : ARB;
            HOLD:    state_next_s = (accept_s && grant_lock_s) ? HOLD : ARB;
            default: state_next_s = ARB;
        endcase
    end

    // Grant selection and RAM port mux; reset forces the port idle immediately.
    always_comb begin
        if (rst) begin
            grant_s = '0;
        end else if (hold_active_s) begin
            grant_s = owner_mask_s;
        end else begin
            grant_s = rr_grant_s;
        end
        grant_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            grant_idx_s = grant_idx_s | (grant_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        accept_s     = |grant_s;
        grant_lock_s = accept_s & req_lock[grant_idx_s];
        grant_op_s   = accept_s & req_op[grant_idx_s];
        req_ready    = grant_s;
        if (accept_s) begin
            phy_ram_addr  = req_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
            phy_ram_write = req_write[int'(grant_idx_s)*DATA_W +: DATA_W];
            phy_ram_op    = grant_op_s;
        end else begin
            phy_ram_addr  = '0;
            phy_ram_write = '0;
            phy_ram_op    = 1'b0;
        end
    end

    // Round-robin pointer, lock owner and burst length; last always equals the owner while locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r      <= IDX_W'(N_REQ - 1);
            owner_r     <= {IDX_W{1'b0}};
            burst_cnt_r <= {BURST_CNT_W{1'b0}};
        end else if (accept_s) begin
            last_r <= grant_idx_s;
            if (!grant_lock_s) begin
                burst_cnt_r <= {BURST_CNT_W{1'b0}};
            end else if (hold_active_s) begin
                burst_cnt_r <= sat_inc(burst_cnt_r);
            end else begin
                owner_r     <= grant_idx_s;
                burst_cnt_r <= BURST_CNT_W'(1);
            end
        end else begin
            burst_cnt_r <= {BURST_CNT_W{1'b0}};
        end
    end

    // Response register: pulse for the accepted requester, data held between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else begin
            rsp_valid_r <= grant_s;
            if (accept_s) begin
                rsp_data_r <= (grant_op_s == RAM_OP_WRITE) ? {DATA_W{1'b0}} : phy_ram_read;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule
